// File: rtl/launch_sequencer.sv
// Stimulus sequencer for the latch-network measurement: clears the capture latches,
// fires four delayed set pulses, then waits for the all-set feedback or a timeout.
module launch_sequencer #(
    parameter int unsigned DLY_W  = 8,
    parameter int unsigned TO_CYC = 16
) (
    input  logic               LS_CLK,
    input  logic               LS_RST,
    input  logic               LS_START,
    input  logic [4*DLY_W-1:0] LS_DLY,
    input  logic [3:0]         LS_MASK,
    input  logic               LS_ALL,
    output logic [3:0]         LS_S,
    output logic               LS_R,
    output logic               LS_BUSY,
    output logic               LS_DONE,
    output logic               LS_TO
);
    localparam int unsigned     TO_W   = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4*DLY_W-1:0] r_dly;
    logic [3:0]         r_mask;
    logic [3:0]         r_fired;
    logic [DLY_W:0]     r_lcnt;
    logic [TO_W-1:0]    r_tcnt;
    logic               r_tflag;
    logic [3:0]         r_s;
    logic               r_r;
    logic               r_busy;
    logic               r_done;
    logic               r_to;

    logic [3:0]         w_hit;
    logic [3:0]         w_fired_nxt;
    logic [DLY_W:0]     w_lcnt_nxt;
    logic [TO_W-1:0]    w_tcnt_nxt;
    logic [TO_W-1:0]    w_tcnt_inc;
    logic               w_tflag_nxt;
    logic [3:0]         w_s_nxt;
    logic               w_capture;

    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_hit[i] = r_mask[i] & ~r_fired[i]
                     & (r_lcnt == {1'b0, r_dly[i*DLY_W +: DLY_W]});
        end
    end

    assign w_tcnt_inc = r_tcnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_fired_nxt = r_fired;
        w_lcnt_nxt  = r_lcnt;
        w_tcnt_nxt  = r_tcnt;
        w_tflag_nxt = r_tflag;
        w_s_nxt     = '0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_done still high means the visible DONE cycle: start is dropped there
                if (LS_START && !r_done) begin
                    w_capture   = 1'b1;
                    w_tflag_nxt = 1'b0;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_lcnt_nxt  = '0;
                w_fired_nxt = ~r_mask;
                w_state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_s_nxt     = w_hit;
                w_fired_nxt = r_fired | w_hit;
                w_lcnt_nxt  = (r_lcnt == '1) ? r_lcnt : r_lcnt + 1'b1;
                if ((r_fired | w_hit) == 4'hF) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Outputs lag state by one cycle, so feedback is honoured from the
                // second WAIT edge onward; the first edge only advances the timer.
                w_tcnt_nxt = w_tcnt_inc;
                if ((r_tcnt != '0) && LS_ALL) begin
                    w_tflag_nxt = 1'b0;
                    w_state_nxt = ST_DONE;
                end else if (w_tcnt_inc == TO_LIM) begin
                    w_tflag_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge LS_CLK) begin
        if (LS_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge LS_CLK) begin
        if (LS_RST) begin
            r_dly   <= '0;
            r_mask  <= '0;
            r_fired <= '0;
            r_lcnt  <= '0;
            r_tcnt  <= '0;
            r_tflag <= 1'b0;
            r_s     <= '0;
            r_r     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_dly  <= LS_DLY;
                r_mask <= LS_MASK;
            end
            r_fired <= w_fired_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_tflag <= w_tflag_nxt;
            r_s     <= w_s_nxt;
            r_r     <= (r_state == ST_CLEAR);
            r_busy  <= (r_state == ST_CLEAR) || (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
            r_done  <= (r_state == ST_DONE);
            if (w_capture) begin
                r_to <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_to <= r_tflag;
            end
        end
    end

    assign LS_S    = r_s;
    assign LS_R    = r_r;
    assign LS_BUSY = r_busy;
    assign LS_DONE = r_done;
    assign LS_TO   = r_to;

endmodule

// File: tb/tb_launch_sequencer.sv
// Bench for launch_sequencer: directed scenarios plus randomized runs, checked every
// cycle against a timeline model built from the edge-offset rules of the sequencer.
module tb_launch_sequencer;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4*DW-1:0] dly = '0;
    logic [3:0]    mask = '0;
    logic          all_fb = 1'b0;
    logic [3:0]    s_o;
    logic          r_o, busy_o, done_o, to_o;

    launch_sequencer #(.DLY_W(DW), .TO_CYC(TO)) dut (
        .LS_CLK(clk), .LS_RST(rst), .LS_START(start), .LS_DLY(dly), .LS_MASK(mask),
        .LS_ALL(all_fb), .LS_S(s_o), .LS_R(r_o), .LS_BUSY(busy_o), .LS_DONE(done_o),
        .LS_TO(to_o)
    );

    always #5 clk = ~clk;

    int nchk = 0, npass = 0, nfail = 0;

    // timeline model: k = edges since the accepted start, D = LS_DONE rise edge
    int   n_abs = 0;
    bit   have_run = 0;
    int   e0 = 0, m_max = 0, d_done = -1;
    int   d_m[4];
    logic [3:0] m_m = '0;
    bit   tf = 0, exp_to = 0;
    logic [7:0] exp_out = '0;

    logic [4*DW-1:0] sc_dly = '0;
    logic [3:0]  sc_mask = '0;
    int          all_mode = 0;   // 0 latch network, 1 hold 0, 2 hold 1, 3 random
    logic [3:0]  lat = '0;
    int          done_seen = 0, done_rel = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit st, input bit rs, input bit all_in);
        int k, w;
        n_abs++;
        if (rs) begin
            have_run = 0;
            exp_to   = 0;
        end else begin
            if (have_run && d_done < 0) begin
                k = n_abs - e0;
                w = 3 + m_max;
                if (k >= w + 1 && k <= w + TO - 1 && all_in) begin
                    d_done = k + 1; tf = 0;
                end else if (k == w + TO - 1) begin
                    d_done = w + TO; tf = 1;
                end
            end
            if (st && !(have_run && (d_done < 0 || n_abs < e0 + d_done + 2))) begin
                have_run = 1;
                e0 = n_abs;
                m_m = mask;
                m_max = 0;
                for (int i = 0; i < 4; i++) begin
                    d_m[i] = int'(dly[i*DW +: DW]);
                    if (m_m[i] && d_m[i] > m_max) m_max = d_m[i];
                end
                d_done = -1;
                exp_to = 0;
            end
            if (have_run && d_done >= 0 && n_abs - e0 == d_done) exp_to = tf;
        end
        exp_out = {7'b0, exp_to};
        if (have_run) begin
            k = n_abs - e0;
            for (int i = 0; i < 4; i++) exp_out[4+i] = m_m[i] && (k == 2 + d_m[i]);
            exp_out[3] = (k == 1);
            exp_out[2] = (k >= 1) && (d_done < 0 || k < d_done);
            exp_out[1] = (d_done >= 0) && (k == d_done);
        end
    endtask

    task automatic cycle(input bit st, input bit rs);
        start = st;
        rst   = rs;
        dly   = st ? sc_dly : $urandom();
        mask  = st ? sc_mask : 4'($urandom());
        case (all_mode)
            0: all_fb = &lat;
            1: all_fb = 1'b0;
            2: all_fb = 1'b1;
            default: all_fb = 1'($urandom_range(0, 1));
        endcase
        model_edge(st, rs, all_fb);
        @(negedge clk);
        check($sformatf("out@%0d", n_abs), {24'b0, s_o, r_o, busy_o, done_o, to_o}, {24'b0, exp_out});
        if (rs || r_o) lat = '0;
        else           lat = lat | s_o;
        if (done_o) begin
            done_seen++;
            done_rel = n_abs - e0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic launch(input logic [4*DW-1:0] d, input logic [3:0] m);
        sc_dly = d;
        sc_mask = m;
        done_seen = 0;
        done_rel = -1;
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        logic [4*DW-1:0] rd;
        // reset with start held high
        all_mode = 1;
        repeat (3) cycle(1'b1, 1'b1);
        idle(2);

        // staggered {0,3,3,7}: latches full after E9, feedback honoured at E11
        all_mode = 0;
        launch(32'h07_03_03_00, 4'hF);
        idle(20);
        check("stagger_done_cnt", done_seen, 1);
        check("stagger_done_edge", done_rel, 12);

        // minimum run: delays 0, feedback already high
        all_mode = 2;
        launch(32'h00_00_00_00, 4'hF);
        idle(8);
        check("min_done_edge", done_rel, 5);

        // timeout with feedback stuck low
        all_mode = 1;
        launch(32'h02_02_02_02, 4'hF);
        idle(26);
        check("to_done_edge", done_rel, 21);
        check("to_held", to_o, 1);

        // mask 0101 with the maximum delay on channel 0
        all_mode = 0;
        rd = $urandom();
        launch({rd[31:24], 8'd1, rd[15:8], 8'd255}, 4'b0101);
        idle(280);
        check("mask_done_cnt", done_seen, 1);
        check("mask_done_edge", done_rel, 3 + 255 + TO);

        // start pulses in LAUNCH (edge 3) and in the DONE cycle (edge 10), feedback forced early
        launch(32'h03_02_04_01, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            all_mode = (k <= 7) ? 2 : 0;
            cycle(k == 3 || k == 10, 1'b0);
        end
        check("starts_done_cnt", done_seen, 1);
        check("starts_done_edge", done_rel, 9);
        idle(3);

        // reset at E4 of a {6,6,6,6} run, then a fresh staggered run
        all_mode = 0;
        launch(32'h06_06_06_06, 4'hF);
        idle(3);
        cycle(1'b0, 1'b1);
        idle(20);
        check("rst_no_done", done_seen, 0);
        launch(32'h07_03_03_00, 4'hF);
        idle(16);
        check("rerun_done_cnt", done_seen, 1);
        check("rerun_done_edge", done_rel, 12);

        // randomized runs with stray starts and rare resets
        for (int r = 0; r < 40; r++) begin
            all_mode = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) rd[i*DW +: DW] = 8'($urandom_range(0, 12));
            launch(rd, 4'($urandom()));
            for (int j = 0; j < 40; j++)
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
